// File: rtl/debug_exec_ctrl_if.sv
// Debug execution controller bus: command bytes and dump handshake in,
// pipeline enable, status and executed-cycle count out.
interface debug_exec_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             is_start;
  logic [7:0]       i_rx_data;
  logic             is_rx_done;
  logic             is_done_send;
  logic             i_halt;
  logic             os_step;
  logic             os_start_send;
  logic             os_done;
  logic             o_busy;
  logic [1:0]       o_mode;
  logic [CNT_W-1:0] o_clk_count;

  modport master (
    output is_start, i_rx_data, is_rx_done,
    output is_done_send, i_halt,
    input  os_step, os_start_send, os_done,
    input  o_busy, o_mode, o_clk_count
  );

  modport slave (
    input  is_start, i_rx_data, is_rx_done,
    input  is_done_send, i_halt,
    output os_step, os_start_send, os_done,
    output o_busy, o_mode, o_clk_count
  );
endinterface

// File: rtl/debug_exec_ctrl.sv
// Debug execution controller: step, N-step and free-run bursts that gate
// the pipeline enable, then trigger a register/memory dump.
module debug_exec_ctrl #(
  parameter int         CNT_W      = 32,
  parameter int         N_BYTES    = 2,
  parameter int         SETTLE_CYC = 2,
  parameter logic [7:0] CMD_STEP   = 8'h0F,
  parameter logic [7:0] CMD_NSTEP  = 8'h11,
  parameter logic [7:0] CMD_RUN    = 8'h10,
  parameter logic [7:0] CMD_ABORT  = 8'h1F
) (
  input logic               clk,
  input logic               rst,
  debug_exec_ctrl_if.slave  bus
);
  localparam int NW = 8 * N_BYTES;
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N_BYTES - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_STEP  = 2'd1;
  localparam logic [1:0] M_NSTEP = 2'd2;
  localparam logic [1:0] M_RUN   = 2'd3;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WAIT   = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_SETTLE = 4'd4;
  localparam logic [3:0] S_SEND   = 4'd5;
  localparam logic [3:0] S_WSEND  = 4'd6;
  localparam logic [3:0] S_CHECK  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]       state;
  logic [1:0]       mode;
  logic [CNT_W-1:0] cnt;
  logic [NW-1:0]    n_q;
  logic [NW-1:0]    n_next;
  logic [NW-1:0]    rem;
  logic [IW-1:0]    idx;
  logic [SW-1:0]    settle;
  logic             abort;
  logic             exec_end;

  // N register with the incoming count byte merged at the current index
  always_comb begin
    n_next = n_q;
    for (int b = 0; b < N_BYTES; b++) begin
      if (idx == IW'(b)) n_next[8*b +: 8] = bus.i_rx_data;
    end
  end

  assign abort = bus.is_rx_done
              && (bus.i_rx_data == CMD_ABORT)
              && (mode == M_RUN);

  assign exec_end = bus.i_halt || abort
                 || ((mode != M_RUN) && (rem == NW'(1)));

  // control FSM, burst length, settle timer and executed-cycle counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      mode   <= M_NONE;
      cnt    <= '0;
      n_q    <= '0;
      rem    <= '0;
      idx    <= '0;
      settle <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.is_start) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.is_rx_done) begin
            if (bus.i_rx_data == CMD_STEP) begin
              rem   <= NW'(1);
              mode  <= M_STEP;
              state <= S_EXEC;
            end else if (bus.i_rx_data == CMD_RUN) begin
              mode  <= M_RUN;
              state <= S_EXEC;
            end else if (bus.i_rx_data == CMD_NSTEP) begin
              mode  <= M_NSTEP;
              n_q   <= '0;
              idx   <= '0;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.is_rx_done) begin
            n_q <= n_next;
            if (idx == IDX_LAST) begin
              if (n_next == '0) begin
                state <= S_WAIT;
              end else begin
                rem   <= n_next;
                state <= S_EXEC;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_EXEC: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (mode != M_RUN) rem <= rem - NW'(1);
          if (exec_end) begin
            settle <= '0;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle == SET_LAST) state <= S_SEND;
          else settle <= settle + SW'(1);
        end
        S_SEND: begin
          state <= S_WSEND;
        end
        S_WSEND: begin
          if (bus.is_done_send) state <= S_CHECK;
        end
        S_CHECK: begin
          state <= bus.i_halt ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.os_step       = (state == S_EXEC);
  assign bus.os_start_send = (state == S_SEND);
  assign bus.os_done       = (state == S_DONE);
  assign bus.o_busy        = (state != S_IDLE);
  assign bus.o_mode        = mode;
  assign bus.o_clk_count   = cnt;
endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Bench for debug_exec_ctrl: session table plus reset/ignore sequences,
// with a dump scoreboard checked by a monitor; a 4-bit twin checks saturation.
module tb_debug_exec_ctrl;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_exec_ctrl_if #(.CNT_W(32)) mi ();
  debug_exec_ctrl_if #(.CNT_W(4))  si ();

  assign si.is_start     = mi.is_start;
  assign si.i_rx_data    = mi.i_rx_data;
  assign si.is_rx_done   = mi.is_rx_done;
  assign si.is_done_send = mi.is_done_send;
  assign si.i_halt       = mi.i_halt;

  debug_exec_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(mi)
  );

  debug_exec_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(si)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          steps;
    logic [31:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] exp_cnt   = '0;
  logic [3:0]  exp_cnt_s = '0;

  int   steps_seen = 0;
  int   bursts     = 0;
  int   gap        = 0;
  int   dumps      = 0;
  logic prev_step  = 1'b0;

  // monitor: measure each burst and score it when the dump starts
  always @(negedge clk) begin
    if (!rst) begin
      steps_seen = 0;
      bursts     = 0;
      gap        = 0;
      prev_step  = 1'b0;
    end else begin
      if (mi.os_step) begin
        if (!prev_step) bursts++;
        steps_seen++;
        gap = 0;
      end else begin
        gap++;
      end
      prev_step = mi.os_step;
      if (mi.os_start_send) begin
        dumps++;
        chk("dump_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("burst_steps", steps_seen, e.steps);
          chk("burst_contig", bursts, 1);
          chk("settle_gap", gap, SETTLE + 1);
          chk("dump_count", mi.o_clk_count, e.cnt);
          chk("dump_count_sat", si.o_clk_count, 32'(e.cnt_s));
        end
        steps_seen = 0;
        bursts     = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mi.i_rx_data  = b;
    mi.is_rx_done = 1'b1;
    tick();
    mi.is_rx_done = 1'b0;
  endtask

  task automatic pulse_start();
    mi.is_start = 1'b1;
    tick();
    mi.is_start = 1'b0;
  endtask

  task automatic add_steps(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
      if (exp_cnt_s != 4'hF) exp_cnt_s = exp_cnt_s + 1;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_step"}, 32'(mi.os_step), 0);
    chk({tag, "_send"}, 32'(mi.os_start_send), 0);
    chk({tag, "_done"}, 32'(mi.os_done), 0);
    chk({tag, "_busy"}, 32'(mi.o_busy), 0);
    chk({tag, "_mode"}, 32'(mi.o_mode), 0);
    chk({tag, "_cnt"}, mi.o_clk_count, 0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] n;
    int          wait_cyc;
    bit          halt;
    bit          abort;
    int          exp_steps;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vt[6];

  initial begin
    int k;
    int d0;
    vt[0] = '{8'h0F, 16'd0, 0,  1'b0, 1'b0, 1,  2'd1};
    vt[1] = '{8'h11, 16'd5, 0,  1'b0, 1'b0, 5,  2'd2};
    vt[2] = '{8'h11, 16'd3, 0,  1'b0, 1'b0, 3,  2'd2};
    vt[3] = '{8'h11, 16'd0, 0,  1'b0, 1'b0, 0,  2'd2};
    vt[4] = '{8'h10, 16'd0, 40, 1'b0, 1'b1, 41, 2'd3};
    vt[5] = '{8'h10, 16'd0, 12, 1'b1, 1'b0, 13, 2'd3};

    mi.is_start     = 1'b0;
    mi.i_rx_data    = 8'h00;
    mi.is_rx_done   = 1'b0;
    mi.is_done_send = 1'b0;
    mi.i_halt       = 1'b0;

    rst = 1'b0;
    repeat (3) tick();
    chk_idle_zero("rst_hold");
    rst = 1'b1;
    tick();
    chk_idle_zero("rst_release");

    mi.is_done_send = 1'b1;
    tick();
    mi.is_done_send = 1'b0;
    send_byte(8'h0F);
    tick();
    chk_idle_zero("idle_stray");

    pulse_start();
    chk("armed_busy", 32'(mi.o_busy), 1);
    send_byte(8'h42);
    send_byte(8'h1F);
    repeat (3) tick();
    chk("ignore_mode", 32'(mi.o_mode), 0);
    chk("ignore_busy", 32'(mi.o_busy), 1);
    chk("ignore_steps", steps_seen, 0);
    chk("ignore_dumps", dumps, 0);

    for (int v = 0; v < 6; v++) begin
      d0 = dumps;
      if (vt[v].exp_steps > 0) begin
        add_steps(vt[v].exp_steps);
        sb.push_back('{vt[v].exp_steps, exp_cnt, exp_cnt_s});
      end
      send_byte(vt[v].cmd);
      if (vt[v].cmd == 8'h11) begin
        send_byte(vt[v].n[7:0]);
        send_byte(vt[v].n[15:8]);
      end
      repeat (vt[v].wait_cyc) tick();
      if (vt[v].abort) send_byte(8'h1F);
      if (vt[v].halt) mi.i_halt = 1'b1;

      if (vt[v].exp_steps == 0) begin
        repeat (10) tick();
        chk($sformatf("v%0d_nodump", v), dumps, d0);
        chk($sformatf("v%0d_nostep", v), steps_seen, 0);
        chk($sformatf("v%0d_busy", v), 32'(mi.o_busy), 1);
        chk($sformatf("v%0d_mode", v), 32'(mi.o_mode), 32'(vt[v].exp_mode));
      end else begin
        k = 0;
        while (!mi.os_start_send && k < 300) begin
          @(negedge clk);
          k++;
        end
        chk($sformatf("v%0d_dump_seen", v), 32'(mi.os_start_send), 1);
        tick();
        chk($sformatf("v%0d_dumps", v), dumps, d0 + 1);
        chk($sformatf("v%0d_send_1cyc", v), 32'(mi.os_start_send), 0);
        mi.is_done_send = 1'b1;
        tick();
        mi.is_done_send = 1'b0;
        chk($sformatf("v%0d_chk_busy", v), 32'(mi.o_busy), 1);
        chk($sformatf("v%0d_chk_done", v), 32'(mi.os_done), 0);
        tick();
        if (vt[v].halt) begin
          chk($sformatf("v%0d_done", v), 32'(mi.os_done), 1);
          tick();
          mi.i_halt = 1'b0;
          exp_cnt   = '0;
          exp_cnt_s = '0;
          chk($sformatf("v%0d_done_1cyc", v), 32'(mi.os_done), 0);
          chk($sformatf("v%0d_idle", v), 32'(mi.o_busy), 0);
          chk($sformatf("v%0d_cleared", v), mi.o_clk_count, 0);
          chk($sformatf("v%0d_cleared_s", v), 32'(si.o_clk_count), 0);
        end else begin
          chk($sformatf("v%0d_busy", v), 32'(mi.o_busy), 1);
          chk($sformatf("v%0d_done", v), 32'(mi.os_done), 0);
          chk($sformatf("v%0d_mode", v), 32'(mi.o_mode), 32'(vt[v].exp_mode));
          chk($sformatf("v%0d_hold", v), mi.o_clk_count, exp_cnt);
        end
      end
    end

    mi.is_done_send = 1'b1;
    tick();
    mi.is_done_send = 1'b0;
    tick();
    chk("idle_stray2_busy", 32'(mi.o_busy), 0);
    chk("idle_stray2_send", 32'(mi.os_start_send), 0);

    pulse_start();
    send_byte(8'h10);
    repeat (5) tick();
    chk("pre_rst_step", 32'(mi.os_step), 1);
    rst = 1'b0;
    tick();
    chk("rst_drop_step", 32'(mi.os_step), 0);
    tick();
    tick();
    chk_idle_zero("rst_mid");
    rst = 1'b1;
    tick();
    chk_idle_zero("rst_mid_release");
    chk("rst_cnt_s", 32'(si.o_clk_count), 0);
    exp_cnt   = '0;
    exp_cnt_s = '0;

    pulse_start();
    add_steps(1);
    sb.push_back('{1, exp_cnt, exp_cnt_s});
    d0 = dumps;
    send_byte(8'h0F);
    k = 0;
    while (!mi.os_start_send && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("recover_dump_seen", 32'(mi.os_start_send), 1);
    tick();
    chk("recover_dumps", dumps, d0 + 1);
    mi.is_done_send = 1'b1;
    tick();
    mi.is_done_send = 1'b0;
    tick();
    chk("recover_busy", 32'(mi.o_busy), 1);
    chk("recover_cnt", mi.o_clk_count, 1);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
